feature_vector_loader: RTL

Producer side of the logistic-regression inner-product datapath: it collects a serial stream of 32-bit feature samples from the line buffer and presents them as a parallel 41-entry vector `xarray[0:40]` to the combinational inner-product stage.
- Entry 0 is the constant bias term.
- Entries 1..40 are the streamed features.
- A fill buffer plus a held output register (ping-pong) lets the next vector stream in while the current one is being consumed.
- Frame alignment uses a first-beat marker; misaligned beats are dropped and flagged.

---
 rtl/feature_vector_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/feature_vector_loader.sv
// Serial-to-parallel loader for the logistic-regression inner product: streams
// NFEAT samples into a fill buffer, then hands them to a held output vector.
module feature_vector_loader #(
    parameter int             NFEAT = 40,
    parameter int             W     = 32,
    parameter logic [W-1:0]   BIAS  = W'(1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    input  logic         s_first,
    output logic         s_ready,
    output logic [W-1:0] xarray [0:NFEAT],
    output logic         x_valid,
    input  logic         x_ready,
    output logic         sync_err,
    output logic [15:0]  vec_count,
    output logic         dbg_state
);

    // Handshake rule: a sample moves when s_valid & s_ready in the same cycle;
    // a vector is consumed when x_valid & x_ready in the same cycle. Neither
    // side may retract valid data before it has been taken.

    localparam int            CW       = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam int            IW       = CW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NFEAT - 1);

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          load;
    logic          err_d;
    logic          accept;

    logic [W-1:0]  fill_buf [1:NFEAT];
    logic [W-1:0]  xreg     [1:NFEAT];

    assign s_ready   = (state_q == FILL);
    assign accept    = s_valid & s_ready;
    assign dbg_state = (state_q == PEND);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = IW'(cnt_q) + IW'(1);
        load    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (s_first && (cnt_q != '0)) begin
                        // Resync: abandon the partial vector, this beat is feature 1.
                        wr_en  = 1'b1;
                        wr_idx = IW'(1);
                        cnt_d  = CW'(1);
                        err_d  = 1'b1;
                    end else if (!s_first && (cnt_q == '0)) begin
                        // Orphan beat outside any frame: dropped.
                        err_d  = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = PEND;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            PEND: begin
                if (!x_valid || x_ready) begin
                    load    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            x_valid   <= 1'b0;
            sync_err  <= 1'b0;
            vec_count <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_err <= err_d;
            if (load) begin
                x_valid <= 1'b1;
            end else if (x_valid && x_ready) begin
                x_valid <= 1'b0;
            end
            if (x_valid && x_ready) begin
                vec_count <= vec_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= NFEAT; k++) begin
                fill_buf[k] <= '0;
                xreg[k]     <= '0;
            end
        end else begin
            for (int k = 1; k <= NFEAT; k++) begin
                if (wr_en && (wr_idx == IW'(k))) begin
                    fill_buf[k] <= s_data;
                end
                if (load) begin
                    xreg[k] <= fill_buf[k];
                end
            end
        end
    end

    always_comb begin
        xarray[0] = BIAS;
        for (int k = 1; k <= NFEAT; k++) begin
            xarray[k] = xreg[k];
        end
    end

endmodule
